// File: rtl/line_fifo_sequencer.sv
// Phase controller and write-port arbiter for the shared line FIFO between parser,
// solver and assembler; tracks occupancy, solver passes and aborts on faults.
module line_fifo_sequencer #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned FIFO_DEPTH     = 512,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                         clk_50mhz,
    input  logic                         rst,
    input  logic                         parse_write,
    input  logic [DATA_WIDTH-1:0]        parse_line,
    input  logic                         parsed,
    input  logic                         solve_write,
    input  logic [DATA_WIDTH-1:0]        solve_line,
    input  logic                         solve_next,
    input  logic                         progress,
    input  logic                         solved,
    input  logic                         unsolvable,
    input  logic                         assembled,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    output logic [DATA_WIDTH-1:0]        fifo_din,
    output logic                         fifo_wr_en,
    output logic                         fifo_rd_en,
    output logic                         fifo_srst,
    output logic [1:0]                   state,
    output logic                         solver_start,
    output logic                         assembler_start,
    output logic [$clog2(FIFO_DEPTH):0]  occupancy,
    output logic [7:0]                   pass_count,
    output logic [1:0]                   error_code
);

    localparam int unsigned OccW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ErrNone     = 2'd0;
    localparam logic [1:0] ErrOverflow = 2'd1;
    localparam logic [1:0] ErrStall    = 2'd2;
    localparam logic [1:0] ErrTimeout  = 2'd3;

    typedef enum logic [1:0] {
        StReceive  = 2'd0,
        StSolve    = 2'd1,
        StTransmit = 2'd2,
        StError    = 2'd3
    } phase_e;

    phase_e          state_q;
    logic [OccW-1:0] occ_q;
    logic [OccW-1:0] remaining_q;
    logic [7:0]      pass_q;
    logic [1:0]      err_q;
    logic            progress_seen_q;
    logic [WdW-1:0]  wd_q;
    logic            solver_start_q;
    logic            assembler_start_q;
    logic            srst_pulse_q;

    logic            write_req;
    logic            write_acc;
    logic            read_acc;
    logic            overflow;
    logic            pass_end;
    logic            stalled;
    logic            active_phase;
    logic            idle;
    logic            timeout;
    logic [OccW-1:0] occ_next;
    logic [7:0]      pass_inc;

    // Write-port ownership follows the phase; other phases have no writer.
    always_comb begin
        write_req = 1'b0;
        fifo_din  = parse_line;
        unique case (state_q)
            StReceive: write_req = parse_write;
            StSolve: begin
                write_req = solve_write;
                fifo_din  = solve_line;
            end
            default: ;
        endcase
    end

    assign write_acc  = write_req & ~fifo_full & ~rst;
    assign overflow   = write_req & fifo_full;
    assign read_acc   = (state_q == StSolve) & solve_next & ~fifo_empty & ~rst;
    assign fifo_wr_en = write_acc;
    assign fifo_rd_en = read_acc;
    assign fifo_srst  = rst | srst_pulse_q | (state_q == StError);

    always_comb begin
        occ_next = occ_q;
        if (write_acc && !read_acc) begin
            occ_next = occ_q + 1'b1;
        end else if (read_acc && !write_acc) begin
            occ_next = occ_q - 1'b1;
        end
    end

    // A pass ends on the read that consumes the last entry counted at pass start.
    assign pass_end     = read_acc & (remaining_q <= OccW'(1));
    assign stalled      = pass_end & ~(progress_seen_q | progress);
    assign active_phase = (state_q == StSolve) | (state_q == StTransmit);
    assign idle         = ~(write_acc | read_acc | progress);
    assign timeout      = active_phase & idle & (wd_q == WdW'(TIMEOUT_CYCLES - 1));
    assign pass_inc     = (pass_q == 8'hFF) ? 8'hFF : pass_q + 8'd1;

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state_q           <= StReceive;
            occ_q             <= '0;
            remaining_q       <= '0;
            pass_q            <= '0;
            err_q             <= ErrNone;
            progress_seen_q   <= 1'b0;
            wd_q              <= '0;
            solver_start_q    <= 1'b0;
            assembler_start_q <= 1'b0;
            srst_pulse_q      <= 1'b0;
        end else begin
            solver_start_q    <= 1'b0;
            assembler_start_q <= 1'b0;
            srst_pulse_q      <= 1'b0;
            occ_q             <= occ_next;

            if (!active_phase || !idle) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 1'b1;
            end

            unique case (state_q)
                StReceive: begin
                    if (overflow) begin
                        state_q <= StError;
                        err_q   <= ErrOverflow;
                        occ_q   <= '0;
                    end else if (parsed) begin
                        state_q         <= StSolve;
                        solver_start_q  <= 1'b1;
                        remaining_q     <= occ_next;
                        pass_q          <= '0;
                        progress_seen_q <= 1'b0;
                    end
                end

                StSolve: begin
                    if (progress) begin
                        progress_seen_q <= 1'b1;
                    end
                    if (read_acc) begin
                        remaining_q <= remaining_q - 1'b1;
                    end
                    if (pass_end) begin
                        pass_q          <= pass_inc;
                        remaining_q     <= occ_next;
                        progress_seen_q <= 1'b0;
                    end

                    // Exit priority: solved > unsolvable > overflow > stall > timeout.
                    if (solved) begin
                        state_q           <= StTransmit;
                        assembler_start_q <= 1'b1;
                        srst_pulse_q      <= 1'b1;
                        occ_q             <= '0;
                        wd_q              <= '0;
                    end else if (unsolvable) begin
                        state_q <= StError;
                        err_q   <= ErrStall;
                        occ_q   <= '0;
                    end else if (overflow) begin
                        state_q <= StError;
                        err_q   <= ErrOverflow;
                        occ_q   <= '0;
                    end else if (stalled) begin
                        state_q <= StError;
                        err_q   <= ErrStall;
                        occ_q   <= '0;
                    end else if (timeout) begin
                        state_q <= StError;
                        err_q   <= ErrTimeout;
                        occ_q   <= '0;
                    end
                end

                StTransmit: begin
                    if (assembled) begin
                        state_q <= StReceive;
                        wd_q    <= '0;
                    end else if (timeout) begin
                        state_q <= StError;
                        err_q   <= ErrTimeout;
                        occ_q   <= '0;
                    end
                end

                default: ;
            endcase
        end
    end

    assign state           = state_q;
    assign solver_start    = solver_start_q;
    assign assembler_start = assembler_start_q;
    assign occupancy       = occ_q;
    assign pass_count      = pass_q;
    assign error_code      = err_q;

endmodule
